// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd F(2,3) filter-transform sequencer.
//   DATA_W  : width of one filter tap / one transformed result
//   ROW_W   : packed filter row {w3,w2,w1}
//   RES_W   : packed transform result {r4,r3,r2,r1}
//   LAT_DEF : default G*w datapath latency
//   state_t : sequencer FSM states
package winograd_pkg;

    localparam int DATA_W  = 32;
    localparam int ROW_W   = 3 * DATA_W;
    localparam int RES_W   = 4 * DATA_W;
    localparam int LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/wt_inflight_pipe.sv
// In-flight row tracker: a shift line of DEPTH stages, each carrying a
// valid flag and the row's destination offset.
//   clk     : rising-edge clock
//   rst     : synchronous clear of every valid flag
//   in_vld  : row issued this cycle (the tracker's stage 0)
//   in_off  : destination offset of that row
//   vld     : valid flags, bit k is stage k+1
//   out_off : destination offset held in the last stage
module wt_inflight_pipe #(
    parameter int DEPTH = 3,
    parameter int OFF_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [OFF_W-1:0] in_off,
    output logic [DEPTH-1:0] vld,
    output logic [OFF_W-1:0] out_off
);

    logic [DEPTH-1:0] vld_p;
    logic [OFF_W-1:0] off_p [DEPTH];

    // stage k-1 -> stage k, valid flags (control, cleared by reset)
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p <= {vld_p[DEPTH-2:0], in_vld};
        end
    end

    // stage k-1 -> stage k, offsets (data, only meaningful with vld_p)
    always_ff @(posedge clk) begin
        off_p[0] <= in_off;
        for (int k = 1; k < DEPTH; k++) begin
            off_p[k] <= off_p[k-1];
        end
    end

    assign vld     = vld_p;
    assign out_off = off_p[DEPTH-1];

endmodule

// File: rtl/winograd_wt_sched.sv
// Sequencer for the Winograd F(2,3) filter transform (G*w). Streams
// cfg_count rows from the weight memory into the datapath, one per cycle,
// and writes each transformed result to the buffer LAT cycles later.
//   clk, rst                : clock, synchronous active-high reset
//   start, cfg_*            : run request and its configuration (IDLE only)
//   busy, done              : run in progress / one-cycle completion pulse
//   wmem_rd_en/addr/rdata   : weight-memory read port (1-cycle read latency)
//   w1..w3, w_valid         : datapath inputs
//   r1..r4                  : datapath outputs
//   ubuf_we/addr/wdata      : transformed-weight buffer write port
module winograd_wt_sched
    import winograd_pkg::*;
#(
    parameter int LAT    = LAT_DEF,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_count,
    input  logic [ADDR_W-1:0]        cfg_src_base,
    input  logic [ADDR_W-1:0]        cfg_dst_base,
    output logic                     busy,
    output logic                     done,
    output logic                     wmem_rd_en,
    output logic [ADDR_W-1:0]        wmem_addr,
    input  logic [ROW_W-1:0]         wmem_rdata,
    output logic signed [DATA_W-1:0] w1,
    output logic signed [DATA_W-1:0] w2,
    output logic signed [DATA_W-1:0] w3,
    output logic                     w_valid,
    input  logic signed [DATA_W-1:0] r1,
    input  logic signed [DATA_W-1:0] r2,
    input  logic signed [DATA_W-1:0] r3,
    input  logic signed [DATA_W-1:0] r4,
    output logic                     ubuf_we,
    output logic [ADDR_W-1:0]        ubuf_addr,
    output logic [RES_W-1:0]         ubuf_wdata
);

    localparam int DEPTH = 1 + LAT;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    idx_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic                accept;
    logic                issue;
    logic                last_issue;
    logic                pending;
    logic [DEPTH-1:0]    trk_vld;
    logic [ADDR_W-1:0]   trk_off;

    assign accept     = (state == IDLE) && start;
    assign issue      = (state == ISSUE);
    assign last_issue = issue && (idx_q == count_q - CNT_W'(1));

    // The last stage is written out this cycle, so the tracker is empty next
    // cycle as soon as every earlier stage is clear. Leaving DRAIN on that
    // condition puts done exactly one cycle after the final write.
    assign pending = |trk_vld[DEPTH-2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            count_q <= cfg_count;
            src_q   <= cfg_src_base;
            dst_q   <= cfg_dst_base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            idx_q <= '0;
        end else if (issue) begin
            idx_q <= idx_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (cfg_count == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign wmem_rd_en = issue;
    assign wmem_addr  = issue ? (src_q + ADDR_W'(idx_q)) : '0;

    // issue (stage 0) -> datapath input (stage 1) -> buffer write (stage 1+LAT)
    wt_inflight_pipe #(
        .DEPTH (DEPTH),
        .OFF_W (ADDR_W)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (issue),
        .in_off  (ADDR_W'(idx_q)),
        .vld     (trk_vld),
        .out_off (trk_off)
    );

    assign w_valid = trk_vld[0];
    assign w1      = wmem_rdata[DATA_W-1:0];
    assign w2      = wmem_rdata[2*DATA_W-1:DATA_W];
    assign w3      = wmem_rdata[3*DATA_W-1:2*DATA_W];

    assign ubuf_we    = trk_vld[DEPTH-1];
    assign ubuf_addr  = ubuf_we ? (dst_q + trk_off) : '0;
    assign ubuf_wdata = {r4, r3, r2, r1};

endmodule
